// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package deserializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cntr_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/deserializer_if.sv
// Output word handshake between the deserializer (master) and its consumer (slave).
interface deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/deserializer_out_reg.sv
// Single-entry holding register for completed words; flags a word that finds the register occupied.
module deser_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_ovf_set
);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        o_ovf_set = 1'b0;
        if (i_load) begin
            // A consumer taking the old word frees the slot in the same cycle.
            if (!valid_q || i_ready) begin
                data_d  = i_word;
                valid_d = 1'b1;
            end else begin
                o_ovf_set = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/deserializer.sv
// Rebuilds LSB-first serial words into a parallel handshake output.
// DESERIALIZER_FRAME_CHECK_EN: a gap in i_valid mid-word aborts the word and pulses o_frame_err.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_data,
    deserializer_if.master   out_if,
    output logic             o_overflow,
    input  logic             i_clr_ovf,
    output logic             o_frame_err
);

    localparam int CNTR_BITS = cntr_bits(DATA_WIDTH);
    localparam logic [CNTR_BITS-1:0] CNTR_LAST = CNTR_BITS'(DATA_WIDTH - 1);

    state_t                state_d, state_q;
    logic [CNTR_BITS-1:0]  cntr_d, cntr_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic                  ovf_d, ovf_q;
    logic                  word_done;
    logic                  ovf_set;
`ifdef DESERIALIZER_FRAME_CHECK_EN
    logic                  frame_err_d, frame_err_q;
`endif

    always_comb begin
        state_d   = state_q;
        cntr_d    = cntr_q;
        shift_d   = shift_q;
        word_done = 1'b0;
`ifdef DESERIALIZER_FRAME_CHECK_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    shift_d = {{(DATA_WIDTH-1){1'b0}}, i_data};
                    cntr_d  = CNTR_BITS'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (i_valid) begin
                    shift_d[cntr_q] = i_data;
                    if (cntr_q == CNTR_LAST) begin
                        word_done = 1'b1;
                        cntr_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        cntr_d = cntr_q + CNTR_BITS'(1);
                    end
                end else begin
`ifdef DESERIALIZER_FRAME_CHECK_EN
                    cntr_d      = '0;
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cntr_d  = '0;
            end
        endcase
    end

    // Set beats clear so a drop coinciding with i_clr_ovf is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clr_ovf) ovf_d = 1'b0;
        if (ovf_set)   ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cntr_q  <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef DESERIALIZER_FRAME_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) frame_err_q <= 1'b0;
        else       frame_err_q <= frame_err_d;
    end
    assign o_frame_err = frame_err_q;
`else
    assign o_frame_err = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;

    deser_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (word_done),
        .i_word    (shift_d),
        .i_ready   (out_if.ready),
        .o_data    (out_data),
        .o_valid   (out_valid),
        .o_ovf_set (ovf_set)
    );

    assign out_if.data  = out_data;
    assign out_if.valid = out_valid;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer at DATA_WIDTH=8.
module tb_deserializer;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_valid;
    logic i_data;
    logic i_clr_ovf;
    logic o_overflow;
    logic o_frame_err;

    int n_checks = 0;
    int n_fails  = 0;

    deserializer_if #(.DATA_WIDTH(8)) dif ();

    deserializer #(.DATA_WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .out_if      (dif),
        .o_overflow  (o_overflow),
        .i_clr_ovf   (i_clr_ovf),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            i_valid = 1'b1;
            i_data  = w[i];
            step();
        end
        i_valid = 1'b0;
        i_data  = 1'b0;
    endtask

    initial begin
        i_rst     = 1'b1;
        i_valid   = 1'b0;
        i_data    = 1'b0;
        i_clr_ovf = 1'b0;
        dif.ready = 1'b1;
        step();
        step();
        chk("rst_valid", {31'd0, dif.valid}, 32'd0);
        chk("rst_data", {24'd0, dif.data}, 32'h00);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("rst_ferr", {31'd0, o_frame_err}, 32'd0);
        i_rst = 1'b0;
        step();

        // Single word, latency check
        send_bits(8'hA5, 0, 6);
        chk("a5_before_last", {31'd0, dif.valid}, 32'd0);
        send_bits(8'hA5, 7, 7);
        chk("a5_valid", {31'd0, dif.valid}, 32'd1);
        chk("a5_data", {24'd0, dif.data}, 32'hA5);
        chk("a5_ovf", {31'd0, o_overflow}, 32'd0);
        step();
        chk("a5_consumed", {31'd0, dif.valid}, 32'd0);

        // Back-to-back words with the minimum one-cycle gap
        send_bits(8'h3C, 0, 7);
        chk("3c_valid", {31'd0, dif.valid}, 32'd1);
        chk("3c_data", {24'd0, dif.data}, 32'h3C);
        step();
        chk("3c_gap_valid", {31'd0, dif.valid}, 32'd0);
        send_bits(8'hC3, 0, 7);
        chk("c3_valid", {31'd0, dif.valid}, 32'd1);
        chk("c3_data", {24'd0, dif.data}, 32'hC3);
        chk("c3_ovf", {31'd0, o_overflow}, 32'd0);
        step();

        // Overflow with consumer stalled
        dif.ready = 1'b0;
        send_bits(8'h11, 0, 7);
        chk("11_valid", {31'd0, dif.valid}, 32'd1);
        chk("11_data", {24'd0, dif.data}, 32'h11);
        step();
        send_bits(8'h22, 0, 7);
        chk("ovf_set", {31'd0, o_overflow}, 32'd1);
        chk("ovf_data_held", {24'd0, dif.data}, 32'h11);
        chk("ovf_valid_held", {31'd0, dif.valid}, 32'd1);
        dif.ready = 1'b1;
        step();
        chk("11_consumed", {31'd0, dif.valid}, 32'd0);
        chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
        i_clr_ovf = 1'b1;
        step();
        i_clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, o_overflow}, 32'd0);

        // Completion while consumer takes the previous word
        dif.ready = 1'b0;
        send_bits(8'h55, 0, 7);
        chk("55_data", {24'd0, dif.data}, 32'h55);
        step();
        send_bits(8'h66, 0, 6);
        dif.ready = 1'b1;
        send_bits(8'h66, 7, 7);
        chk("66_valid", {31'd0, dif.valid}, 32'd1);
        chk("66_data", {24'd0, dif.data}, 32'h66);
        chk("66_ovf", {31'd0, o_overflow}, 32'd0);
        step();
        chk("66_consumed", {31'd0, dif.valid}, 32'd0);

        // Gap in i_valid after four bits
        send_bits(8'hFF, 0, 3);
        step();
`ifdef DESERIALIZER_FRAME_CHECK_EN
        chk("ferr_pulse", {31'd0, o_frame_err}, 32'd1);
        chk("ferr_no_valid", {31'd0, dif.valid}, 32'd0);
        step();
        chk("ferr_one_cycle", {31'd0, o_frame_err}, 32'd0);
        send_bits(8'h0F, 0, 7);
`else
        chk("pause_no_ferr", {31'd0, o_frame_err}, 32'd0);
        chk("pause_no_valid", {31'd0, dif.valid}, 32'd0);
        step();
        send_bits(8'h0F, 4, 7);
`endif
        chk("0f_valid", {31'd0, dif.valid}, 32'd1);
        chk("0f_data", {24'd0, dif.data}, 32'h0F);
        chk("0f_ovf", {31'd0, o_overflow}, 32'd0);
        step();

        // Reset mid-word; the stale value in o_data must also clear
        dif.ready = 1'b0;
        send_bits(8'h77, 0, 7);
        step();
        send_bits(8'hFF, 0, 4);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_data  = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, dif.valid}, 32'd0);
        chk("mid_rst_data", {24'd0, dif.data}, 32'h00);
        chk("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("mid_rst_ferr", {31'd0, o_frame_err}, 32'd0);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_data  = 1'b0;
        dif.ready = 1'b1;
        step();
        send_bits(8'h81, 0, 7);
        chk("81_valid", {31'd0, dif.valid}, 32'd1);
        chk("81_data", {24'd0, dif.data}, 32'h81);
        step();
        chk("81_consumed", {31'd0, dif.valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Downstream neighbour of the serializer: rebuilds parallel words from a 1-bit stream.
- Stream is LSB first, one bit per clock, qualified by i_valid. i_valid connects directly to the serializer's busy output.
- Completed words go into a single-entry output register with a valid/ready handshake.
- The serial side cannot stall, so a word that arrives while the output is still occupied is dropped and flagged.

Parameters:
- DATA_WIDTH, 8, bits per word; must be >= 2. Counter width is CNTR_BITS = $clog2(DATA_WIDTH).

Ports:
- i_clk  input  1  clock; all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  serial bit qualifier (serializer busy).
- i_data  input  1  serial bit, LSB first.
- o_data  output  DATA_WIDTH  assembled word; stable while o_valid=1.
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
- o_overflow  output  1  sticky: a completed word was dropped.
- i_clr_ovf  input  1  clears o_overflow.
- o_frame_err  output  1  one-cycle pulse: word aborted mid-frame (only with the optional feature).

Behaviour:
- Reset (i_rst=1 at posedge): state=IDLE, counter=0, shift register=0, o_data=0, o_valid=0, o_overflow=0, o_frame_err=0. Reset in mid-word discards the partial word; reset wins over every other event.
- State machine, two states:
  - IDLE: on i_valid=1, capture i_data into bit 0, set counter=1, go to SHIFT.
  - SHIFT: on i_valid=1, capture i_data into bit[counter], counter+1.
  - SHIFT, counter==DATA_WIDTH-1 with i_valid=1: word complete. Next state is IDLE, counter=0.
- Back-to-back words: the serializer idles at least one cycle between words. The block still accepts i_valid=1 in IDLE on the cycle right after completion.
- Latency: o_valid rises the cycle after the cycle that supplied the last bit.
- Completion vs. output register:
  - o_valid=0: load o_data, o_valid<=1.
  - o_valid=1 and i_ready=1 in the same cycle: load the new word, o_valid stays 1.
  - o_valid=1 and i_ready=0: drop the new word, keep the old o_data, o_overflow<=1.
- Handshake:
  - o_valid && i_ready with no completion: o_valid<=0. o_data keeps its last value.
  - o_data must not change while o_valid=1 && !i_ready.
- i_clr_ovf=1: o_overflow<=0. If a new overflow happens in the same cycle, set wins.
- i_valid=0 in IDLE: no change.
- i_valid=0 in SHIFT: depends on the optional feature below.
- Counter never exceeds DATA_WIDTH-1.

Optional Feature:
- Macro: DESERIALIZER_FRAME_CHECK_EN.
- Defined:
  - i_valid=0 in SHIFT is a frame error. Discard the partial word: counter=0, state=IDLE.
  - o_frame_err=1 for exactly the next cycle.
  - Output register and o_overflow unaffected.
- Undefined:
  - i_valid=0 in SHIFT pauses: counter and partial word hold, and assembly resumes on the next i_valid=1.
  - o_frame_err tied to 0.

Decomposition:
- Package deserializer_pkg:
  - state_t enum {IDLE, SHIFT}
  - function cntr_bits(width) returning $clog2(width)
- One natural sub-module: deser_out_reg, the single-entry output holding register. Inputs: load, word, ready. Outputs: data, valid, overflow-set.
- Shift/counter/FSM logic stays in the top.

Test Plan (DATA_WIDTH=8):
- Send 0xA5 LSB first (1,0,1,0,0,1,0,1) with i_valid high for 8 cycles, i_ready=1 -> o_valid=1 for one cycle, exactly 1 cycle after the 8th bit, o_data=0xA5; o_overflow=0.
- Drive the real serializer back-to-back with 0x3C then 0xC3, i_ready=1 -> two o_valid pulses carrying 0x3C then 0xC3; no overflow.
- i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, o_valid held, o_overflow=1 after the second word. Then i_ready=1 -> 0x11 consumed. Then i_clr_ovf=1 -> o_overflow=0.
- o_valid=1 (0x55) and i_ready=1 in the same cycle the last bit of 0x66 arrives -> next cycle o_valid=1, o_data=0x66; o_overflow=0.
- Drop i_valid after 4 bits, then send 0x0F:
  - With DESERIALIZER_FRAME_CHECK_EN: o_frame_err pulses one cycle, then 0x0F received intact.
  - Without it: the first 4 bits are kept and the frame completes on the next 4 bits.
- Assert i_rst at bit 5 of a word, release, send 0x81 -> all outputs 0 during reset, then o_data=0x81 with no stale bits.
